// File: rtl/ladybird_bus_pkg.sv
// Shared types and helpers for the ladybird bus arbiter slice.
// Used by ladybird_bus_arbiter_rr (option macro LADYBIRD_ARB_FIXED_PRIO_EN) and its bench.
package ladybird_bus_pkg;

   localparam int BUS_AW = 32;
   localparam int BUS_DW = 32;
   localparam int BUS_SW = BUS_DW / 8;

   typedef struct packed {
      logic              req;
      logic [BUS_SW-1:0] wstrb;
      logic [BUS_AW-1:0] addr;
      logic [BUS_DW-1:0] wdata;
   } bus_req_t;

   // A master index is always at least one bit wide, even when N_INPUT is 1.
   function automatic int idx_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ladybird_route_fifo.sv
// Small synchronous FIFO that holds the master index of every accepted request
// so that in-order responses can be routed back to the right master.
module ladybird_route_fifo
   import ladybird_bus_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wrPtr;
   logic [PW-1:0]    r_rdPtr;
   logic [PW:0]      r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign o_full   = (r_count == (PW+1)'(DEPTH));
   assign o_empty  = (r_count == '0);
   assign w_doPush = i_push & ~o_full;
   assign w_doPop  = i_pop & ~o_empty;
   assign o_head   = r_mem[r_rdPtr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_doPush) begin
         r_mem[r_wrPtr] <= i_data;
      end
   end

endmodule

// File: rtl/ladybird_bus_arbiter_rr.sv
// N-to-1 pipelined bus arbiter: round-robin select, request lock, in-order response routing.
// Define LADYBIRD_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (master 0 highest).
module ladybird_bus_arbiter_rr
   import ladybird_bus_pkg::*;
#(
   parameter int N_INPUT         = 2,
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    clk,
   input  logic                    arst,
   input  logic [N_INPUT-1:0]      in_req,
   input  logic [N_INPUT*DW/8-1:0] in_wstrb,
   input  logic [N_INPUT*AW-1:0]   in_addr,
   input  logic [N_INPUT*DW-1:0]   in_wdata,
   output logic [N_INPUT-1:0]      in_gnt,
   output logic [N_INPUT-1:0]      in_data_gnt,
   output logic [DW-1:0]           in_rdata,
   output logic                    out_req,
   output logic [DW/8-1:0]         out_wstrb,
   output logic [AW-1:0]           out_addr,
   output logic [DW-1:0]           out_wdata,
   input  logic                    out_gnt,
   input  logic                    out_data_gnt,
   input  logic [DW-1:0]           out_rdata,
   output logic                    o_resp_err
);

   localparam int IW = idx_w(N_INPUT);
   localparam int SW = DW / 8;

   logic [IW-1:0] w_rrPtr;
   logic [IW-1:0] w_sel;
   logic          w_outReq;
   logic          w_accept;
   logic          w_pop;
   logic          w_fifoFull;
   logic          w_fifoEmpty;
   logic [IW-1:0] w_head;
   logic          r_lock;
   logic [IW-1:0] r_lockIdx;
   logic          r_respErr;

`ifdef LADYBIRD_ARB_FIXED_PRIO_EN
   assign w_rrPtr = '0;
`else
   logic [IW-1:0] r_rrPtr;
   logic [IW-1:0] w_selNext;

   assign w_selNext = (w_sel == IW'(N_INPUT - 1)) ? '0 : w_sel + 1'b1;
   assign w_rrPtr   = r_rrPtr;

   // The master after the one just accepted gets first look next time.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_rrPtr <= '0;
      end else if (w_accept) begin
         r_rrPtr <= w_selNext;
      end
   end
`endif

   // A held lock pins the choice; otherwise scan upward from the pointer with wrap.
   always_comb begin
      logic found;
      int   j;
      w_sel = w_rrPtr;
      found = 1'b0;
      j     = 0;
      if (r_lock) begin
         w_sel = r_lockIdx;
      end else begin
         for (int k = 0; k < N_INPUT; k++) begin
            j = int'(w_rrPtr) + k;
            if (j >= N_INPUT) j = j - N_INPUT;
            if (!found && in_req[j]) begin
               found = 1'b1;
               w_sel = IW'(j);
            end
         end
      end
   end

   // Full is count-based only, so a same-cycle response never reopens the request path.
   assign w_outReq = ~arst & in_req[w_sel] & ~w_fifoFull;
   assign w_accept = w_outReq & out_gnt;
   assign w_pop    = out_data_gnt & ~w_fifoEmpty;
   assign out_req  = w_outReq;

   always_comb begin
      out_wstrb = '0;
      out_addr  = '0;
      out_wdata = '0;
      for (int i = 0; i < N_INPUT; i++) begin
         if (w_outReq && (w_sel == IW'(i))) begin
            out_wstrb = in_wstrb[i*SW +: SW];
            out_addr  = in_addr[i*AW +: AW];
            out_wdata = in_wdata[i*DW +: DW];
         end
      end
   end

   always_comb begin
      in_gnt      = '0;
      in_data_gnt = '0;
      if (w_accept) in_gnt[w_sel] = 1'b1;
      if (w_pop)    in_data_gnt[w_head] = 1'b1;
   end

   assign in_rdata = w_pop ? out_rdata : '0;

   // A stalled request is locked in place; a master that withdraws releases the lock.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_lock    <= 1'b0;
         r_lockIdx <= '0;
      end else if (w_accept) begin
         r_lock    <= 1'b0;
      end else if (w_outReq) begin
         r_lock    <= 1'b1;
         r_lockIdx <= w_sel;
      end else if (r_lock && !in_req[r_lockIdx]) begin
         r_lock    <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_respErr <= 1'b0;
      end else if (out_data_gnt && w_fifoEmpty) begin
         r_respErr <= 1'b1;
      end
   end

   assign o_resp_err = r_respErr;

   ladybird_route_fifo #(
      .WIDTH (IW),
      .DEPTH (MAX_OUTSTANDING)
   ) u_routeFifo (
      .clk     (clk),
      .arst    (arst),
      .i_push  (w_accept),
      .i_data  (w_sel),
      .i_pop   (out_data_gnt),
      .o_full  (w_fifoFull),
      .o_empty (w_fifoEmpty),
      .o_head  (w_head)
   );

endmodule

// File: tb/tb_ladybird_bus_arbiter_rr.sv
// Scoreboard bench for ladybird_bus_arbiter_rr: a queue-based reference model predicts
// each cycle's outputs at issue time and a negedge monitor compares them.
module tb_ladybird_bus_arbiter_rr;
   import ladybird_bus_pkg::*;

   localparam int N    = 2;
   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int SW   = DW / 8;
   localparam int MAXO = 4;

   logic              clk = 1'b0;
   logic              arst;
   logic [N-1:0]      in_req;
   logic [N*SW-1:0]   in_wstrb;
   logic [N*AW-1:0]   in_addr;
   logic [N*DW-1:0]   in_wdata;
   logic [N-1:0]      in_gnt;
   logic [N-1:0]      in_data_gnt;
   logic [DW-1:0]     in_rdata;
   logic              out_req;
   logic [SW-1:0]     out_wstrb;
   logic [AW-1:0]     out_addr;
   logic [DW-1:0]     out_wdata;
   logic              out_gnt;
   logic              out_data_gnt;
   logic [DW-1:0]     out_rdata;
   logic              o_resp_err;

   typedef struct {
      bus_req_t      down;
      logic [N-1:0]  gnt;
      logic [N-1:0]  dataGnt;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t expQ[$];
   int   mIds[$];
   int   mPtr;
   int   mLock;
   bit   mErr;
   int   compared;
   int   mismatched;

   ladybird_bus_arbiter_rr #(
      .N_INPUT         (N),
      .AW              (AW),
      .DW              (DW),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk          (clk),
      .arst         (arst),
      .in_req       (in_req),
      .in_wstrb     (in_wstrb),
      .in_addr      (in_addr),
      .in_wdata     (in_wdata),
      .in_gnt       (in_gnt),
      .in_data_gnt  (in_data_gnt),
      .in_rdata     (in_rdata),
      .out_req      (out_req),
      .out_wstrb    (out_wstrb),
      .out_addr     (out_addr),
      .out_wdata    (out_wdata),
      .out_gnt      (out_gnt),
      .out_data_gnt (out_data_gnt),
      .out_rdata    (out_rdata),
      .o_resp_err   (o_resp_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Drive one cycle of stimulus and push the outputs the rules predict for it.
   task automatic applyStimulus(input logic rstIn, input logic [N-1:0] req, input logic gnt, input logic dgnt);
      exp_t e;
      int   cand;
      int   idx;
      bit   full;
      bit   fwd;
      bit   acc;
      @(posedge clk);
      #1;
      arst         = rstIn;
      in_req       = req;
      out_gnt      = gnt;
      out_data_gnt = dgnt;
      out_rdata    = $urandom();
      for (int i = 0; i < N; i++) begin
         in_addr[i*AW +: AW]  = $urandom();
         in_wdata[i*DW +: DW] = $urandom();
         in_wstrb[i*SW +: SW] = ($urandom_range(0, 3) == 0) ? '0 : SW'($urandom());
      end
      e.down    = '0;
      e.gnt     = '0;
      e.dataGnt = '0;
      e.rdata   = '0;
      e.err     = 1'b0;
      if (rstIn) begin
         mPtr  = 0;
         mLock = -1;
         mIds.delete();
         mErr  = 1'b0;
      end else begin
         e.err = mErr;
         full  = (mIds.size() == MAXO);
         cand  = -1;
         if (mLock >= 0) begin
            cand = mLock;
         end else begin
            for (int k = 0; k < N; k++) begin
               idx = (mPtr + k) % N;
               if (cand < 0 && req[idx]) cand = idx;
            end
         end
         fwd = (cand >= 0) && req[cand] && !full;
         acc = fwd && gnt;
         if (fwd) begin
            e.down.req   = 1'b1;
            e.down.wstrb = in_wstrb[cand*SW +: SW];
            e.down.addr  = in_addr[cand*AW +: AW];
            e.down.wdata = in_wdata[cand*DW +: DW];
         end
         if (acc) e.gnt[cand] = 1'b1;
         if (dgnt) begin
            if (mIds.size() > 0) begin
               e.dataGnt[mIds[0]] = 1'b1;
               e.rdata = out_rdata;
               void'(mIds.pop_front());
            end else begin
               mErr = 1'b1;
            end
         end
         if (acc) begin
            mIds.push_back(cand);
`ifdef LADYBIRD_ARB_FIXED_PRIO_EN
            mPtr = 0;
`else
            mPtr = (cand + 1) % N;
`endif
            mLock = -1;
         end else if (fwd) begin
            mLock = cand;
         end else if (mLock >= 0 && !req[mLock]) begin
            mLock = -1;
         end
      end
      expQ.push_back(e);
   endtask

   task automatic drain();
      while (mIds.size() > 0) applyStimulus(1'b0, '0, 1'b0, 1'b1);
   endtask

   // Monitor: compare whatever the DUT presents against the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("out_req",     64'(out_req),     64'(e.down.req));
            checkOutput("out_addr",    64'(out_addr),    64'(e.down.addr));
            checkOutput("out_wstrb",   64'(out_wstrb),   64'(e.down.wstrb));
            checkOutput("out_wdata",   64'(out_wdata),   64'(e.down.wdata));
            checkOutput("in_gnt",      64'(in_gnt),      64'(e.gnt));
            checkOutput("in_data_gnt", 64'(in_data_gnt), 64'(e.dataGnt));
            checkOutput("o_resp_err",  64'(o_resp_err),  64'(e.err));
            if (e.dataGnt != '0) checkOutput("in_rdata", 64'(in_rdata), 64'(e.rdata));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached with %0d predictions pending", expQ.size());
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      compared     = 0;
      mismatched   = 0;
      mPtr         = 0;
      mLock        = -1;
      mErr         = 1'b0;
      arst         = 1'b1;
      in_req       = '0;
      in_wstrb     = '0;
      in_addr      = '0;
      in_wdata     = '0;
      out_gnt      = 1'b0;
      out_data_gnt = 1'b0;
      out_rdata    = '0;

      $display("[TB] reset with requests and responses asserted");
      applyStimulus(1'b1, 2'b11, 1'b1, 1'b1);
      applyStimulus(1'b1, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

      $display("[TB] round-robin alternation");
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b11, 1'b1, 1'b0);
      drain();

      $display("[TB] lock holds stalled master 0");
      applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0);
      drain();

      $display("[TB] full FIFO back-pressure");
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b1);
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
      drain();

      $display("[TB] in-order response routing");
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b10, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'b0, N'($urandom()), ($urandom_range(0, 3) != 0),
                       (mIds.size() > 0) && ($urandom_range(0, 2) == 0));
      end
      drain();

      $display("[TB] stray response sets sticky error");
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);

      $display("[TB] reset mid-transaction discards in-flight IDs");
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b10, 1'b1, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
